// File: rtl/i2c_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_pkg
// Description : Shared definitions for the I2C slave core: FSM state encoding,
//               ACK/NACK line levels and the byte width.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_slave_pkg;

    localparam int   c_byte_w = 8;
    localparam logic c_ack    = 1'b0;
    localparam logic c_nack   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_DATA  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_slave_core_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_filter
// Description : Synchroniser + glitch filter for one open-drain I2C line, with
//               single-cycle rise/fall pulses on the filtered level.
//               Latency from raw input to filtered edge: SYNC_STAGES+GLITCH_LEN.
// Ports       : clk, rst     core clock, async active-high reset
//               i_line       raw line
//               o_level      filtered level (resets to 1, idle bus)
//               o_rise       1-cycle pulse when o_level goes 0->1
//               o_fall       1-cycle pulse when o_level goes 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int c_cnt_w = (GLITCH_LEN > 1) ? $clog2(GLITCH_LEN) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    logic w_sync_out;
    logic w_differs;
    logic w_flip;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_differs  = (w_sync_out != r_level);
    // r_cnt holds how many earlier consecutive samples already disagreed, so
    // the level flips on the GLITCH_LEN-th disagreeing sample.
    assign w_flip     = w_differs && (r_cnt == c_cnt_w'(GLITCH_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '1;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_rise <= w_flip &  w_sync_out;
            r_fall <= w_flip & ~w_sync_out;
            if (w_flip) begin
                r_level <= w_sync_out;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_core.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_core
// Description : I2C target engine. Detects START/Sr/STOP, matches a 7-bit
//               address, ACKs and delivers write bytes, serves read bytes
//               from a byte handshake. Drives the bus open-drain only
//               (*_oe_o = 1 means pull the line low).
// Macro       : I2C_SLAVE_CLOCK_STRETCH_EN - when defined, SCL is held low at
//               a read-byte load until tx_valid_i; otherwise 8'hFF is sent.
// Ports       : i2c_core_clock_i/i2c_core_reset_i  clock, async reset
//               enable_i, own_addr_i               control
//               scl_i/sda_i, scl_oe_o/sda_oe_o     bus
//               rx_data_o/rx_valid_o/rx_full_i      write-byte delivery
//               tx_data_i/tx_valid_i/tx_ready_o     read-byte supply
//               rw_o, addr_match_o, busy_o,
//               start_det_o, stop_det_o            status
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_core
    import i2c_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_LEN  = 3
) (
    input  logic                i2c_core_clock_i,
    input  logic                i2c_core_reset_i,
    input  logic                enable_i,
    input  logic [6:0]          own_addr_i,
    input  logic                scl_i,
    input  logic                sda_i,
    output logic                scl_oe_o,
    output logic                sda_oe_o,
    output logic [c_byte_w-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_full_i,
    input  logic [c_byte_w-1:0] tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic                rw_o,
    output logic                addr_match_o,
    output logic                busy_o,
    output logic                start_det_o,
    output logic                stop_det_o
);

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    localparam logic c_stretch_en = 1'b1;
`else
    localparam logic c_stretch_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Line conditioning
    // ------------------------------------------------------------------
    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_LEN(GLITCH_LEN)) u_scl_filter (
        .clk     (i2c_core_clock_i),
        .rst     (i2c_core_reset_i),
        .i_line  (scl_i),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_LEN(GLITCH_LEN)) u_sda_filter (
        .clk     (i2c_core_clock_i),
        .rst     (i2c_core_reset_i),
        .i_line  (sda_i),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    logic w_start;
    logic w_stop;

    // Both lines share the same filter latency, so the filtered SCL level is
    // aligned with the filtered SDA edge.
    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state,      w_state_nxt;
    logic [3:0]          r_bit_cnt,    w_bit_cnt_nxt;
    logic [c_byte_w-1:0] r_shift,      w_shift_nxt;
    logic                r_phase,      w_phase_nxt;
    logic                r_nack,       w_nack_nxt;
    logic                r_sda_oe,     w_sda_oe_nxt;
    logic                r_scl_oe,     w_scl_oe_nxt;
    logic                r_stretch,    w_stretch_nxt;
    logic                r_busy,       w_busy_nxt;
    logic                r_rw,         w_rw_nxt;
    logic [c_byte_w-1:0] r_rx_data,    w_rx_data_nxt;
    logic                r_rx_valid,   w_rx_valid_nxt;
    logic                r_tx_ready,   w_tx_ready_nxt;
    logic                r_addr_match, w_addr_match_nxt;
    logic                r_start_det,  w_start_det_nxt;
    logic                r_stop_det,   w_stop_det_nxt;
    logic                w_load;
    logic [c_byte_w-1:0] w_byte_in;

    // Byte completed by the bit currently being sampled.
    assign w_byte_in = {r_shift[c_byte_w-2:0], w_sda};

    always_ff @(posedge i2c_core_clock_i or posedge i2c_core_reset_i) begin
        if (i2c_core_reset_i) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_phase      <= 1'b0;
            r_nack       <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_scl_oe     <= 1'b0;
            r_stretch    <= 1'b0;
            r_busy       <= 1'b0;
            r_rw         <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_tx_ready   <= 1'b0;
            r_addr_match <= 1'b0;
            r_start_det  <= 1'b0;
            r_stop_det   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_phase      <= w_phase_nxt;
            r_nack       <= w_nack_nxt;
            r_sda_oe     <= w_sda_oe_nxt;
            r_scl_oe     <= w_scl_oe_nxt;
            r_stretch    <= w_stretch_nxt;
            r_busy       <= w_busy_nxt;
            r_rw         <= w_rw_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_tx_ready   <= w_tx_ready_nxt;
            r_addr_match <= w_addr_match_nxt;
            r_start_det  <= w_start_det_nxt;
            r_stop_det   <= w_stop_det_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // r_phase in the ACK states: 0 = waiting for the SCL fall that opens
    // the ACK bit, 1 = ACK bit on the bus, waiting for the fall that ends it
    // (RD_ACK sets it on the rise once the master's bit has been sampled).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_phase_nxt      = r_phase;
        w_nack_nxt       = r_nack;
        w_sda_oe_nxt     = r_sda_oe;
        // Holding SCL follows the stretch flag, so SCL is released exactly
        // one cycle after the stretched load completes.
        w_scl_oe_nxt     = r_stretch;
        w_stretch_nxt    = r_stretch;
        w_busy_nxt       = r_busy;
        w_rw_nxt         = r_rw;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = 1'b0;
        w_tx_ready_nxt   = 1'b0;
        w_addr_match_nxt = 1'b0;
        w_start_det_nxt  = 1'b0;
        w_stop_det_nxt   = 1'b0;
        w_load           = 1'b0;

        if (!enable_i) begin
            w_state_nxt   = S_IDLE;
            w_sda_oe_nxt  = 1'b0;
            w_scl_oe_nxt  = 1'b0;
            w_stretch_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt     = S_ADDR;
            w_bit_cnt_nxt   = '0;
            w_sda_oe_nxt    = 1'b0;
            w_scl_oe_nxt    = 1'b0;
            w_stretch_nxt   = 1'b0;
            w_busy_nxt      = 1'b1;
            w_start_det_nxt = 1'b1;
        end else if (w_stop) begin
            w_state_nxt    = S_IDLE;
            w_sda_oe_nxt   = 1'b0;
            w_scl_oe_nxt   = 1'b0;
            w_stretch_nxt  = 1'b0;
            w_busy_nxt     = 1'b0;
            w_stop_det_nxt = 1'b1;
        end else if (r_stretch) begin
            // SCL is held low; no bus edges can arrive until the byte shows up.
            if (tx_valid_i) begin
                w_shift_nxt    = tx_data_i;
                w_tx_ready_nxt = 1'b1;
                w_sda_oe_nxt   = ~tx_data_i[c_byte_w-1];
                w_stretch_nxt  = 1'b0;
            end
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte_in;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 4'(c_byte_w - 1)) begin
                            if (w_byte_in[c_byte_w-1:1] == own_addr_i) begin
                                w_addr_match_nxt = 1'b1;
                                w_rw_nxt         = w_byte_in[0];
                                w_state_nxt      = S_ADDR_ACK;
                                w_phase_nxt      = 1'b0;
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt = (c_ack == 1'b0);
                            w_phase_nxt  = 1'b1;
                        end else if (r_rw) begin
                            w_load = 1'b1;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_state_nxt   = S_WR_DATA;
                            w_bit_cnt_nxt = '0;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte_in;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 4'(c_byte_w - 1)) begin
                            // A full consumer means the byte is refused: NACK
                            // and no delivery.
                            if (!rx_full_i) begin
                                w_rx_data_nxt  = w_byte_in;
                                w_rx_valid_nxt = 1'b1;
                                w_nack_nxt     = c_ack;
                            end else begin
                                w_nack_nxt = c_nack;
                            end
                            w_state_nxt = S_WR_ACK;
                            w_phase_nxt = 1'b0;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt = (r_nack == c_ack);
                            w_phase_nxt  = 1'b1;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_state_nxt   = S_WR_DATA;
                            w_bit_cnt_nxt = '0;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'(c_byte_w)) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_RD_ACK;
                            w_phase_nxt  = 1'b0;
                        end else begin
                            w_shift_nxt  = {r_shift[c_byte_w-2:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[c_byte_w-2];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_nack_nxt  = w_sda;
                        w_phase_nxt = 1'b1;
                    end else if (w_scl_fall && r_phase) begin
                        if (r_nack == c_nack) begin
                            w_state_nxt = S_IGNORE;
                        end else begin
                            w_load = 1'b1;
                        end
                    end
                end
                S_IDLE, S_IGNORE: begin
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase

            // Shifter load at the SCL fall that opens a read byte.
            if (w_load) begin
                w_state_nxt   = S_RD_DATA;
                w_bit_cnt_nxt = '0;
                if (tx_valid_i) begin
                    w_shift_nxt    = tx_data_i;
                    w_tx_ready_nxt = 1'b1;
                    w_sda_oe_nxt   = ~tx_data_i[c_byte_w-1];
                end else if (c_stretch_en) begin
                    w_stretch_nxt = 1'b1;
                    w_scl_oe_nxt  = 1'b1;
                    w_sda_oe_nxt  = 1'b0;
                end else begin
                    w_shift_nxt  = '1;
                    w_sda_oe_nxt = 1'b0;
                end
            end
        end
    end

    assign scl_oe_o     = r_scl_oe;
    assign sda_oe_o     = r_sda_oe;
    assign rx_data_o    = r_rx_data;
    assign rx_valid_o   = r_rx_valid;
    assign tx_ready_o   = r_tx_ready;
    assign rw_o         = r_rw;
    assign addr_match_o = r_addr_match;
    assign busy_o       = r_busy;
    assign start_det_o  = r_start_det;
    assign stop_det_o   = r_stop_det;

endmodule
`default_nettype wire
